// File: rtl/display_pkg.sv
// Segment encodings and BCD-to-segment decode shared by the 7-segment display driver.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable.
//
// Contents:
//   SEG_BLANK / SEG_MINUS / SEG_ERR : special active-low patterns, bit order {g,f,e,d,c,b,a}
//   DIGIT_SEG                       : active-low patterns for decimal digits 0..9
//   bcd_to_seg()                    : nibble -> pattern, values above 9 map to SEG_ERR
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam logic [6:0] DIGIT_SEG [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    if (v <= 4'd9) begin
      seg = DIGIT_SEG[v];
    end else begin
      seg = SEG_ERR;
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Refresh timer for a multiplexed display: counter runs 0..REFRESH_DIV-1, digit index advances on wrap.
// Latency: idx/cnt are registered state; idx changes on the edge where cnt wraps to 0.
// Backpressure: none; free-running whenever out of reset.
//
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-low reset (clears counter and index)
//   idx   out  current digit index, 0..N_DIGITS-1
//   cnt   out  current refresh count within the digit slot, 0..REFRESH_DIV-1
module seg_scan_timer #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(N_DIGITS)-1:0]    idx,
  output logic [$clog2(REFRESH_DIV)-1:0] cnt
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      // Index width may cover more values than N_DIGITS, so wrap explicitly.
      if (idx_q == IW'(N_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/display_7seg_mux_param.sv
// N-digit common-anode 7-segment multiplexer: shadowed sign+BCD value, leading-zero blanking, floating minus, error flag.
// Latency: load captures into the shadow at the edge; catodo/anodo/data_err are registered one cycle behind shadow and index.
// Backpressure: none; load is a plain strobe, the value is recaptured on every cycle it is high.
//
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   load            capture codigo_BCD/signo into the shadow register
//   codigo_BCD      packed BCD magnitude, nibble 0 least significant, N_DIGITS-1 nibbles
//   signo           1 = negative
//   brillo          (only with DISPLAY_DIM_EN defined) 3-bit brightness, 7 = full on-time
//   anodo           active-low digit enables, bit i = digit i
//   catodo          active-low segments {g,f,e,d,c,b,a}
//   data_err        shadow holds at least one nibble above 9
// Optional feature macro: DISPLAY_DIM_EN.
module display_7seg_mux_param
  import display_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*(N_DIGITS-1)-1:0] codigo_BCD,
  input  logic                      signo,
`ifdef DISPLAY_DIM_EN
  input  logic [2:0]                brillo,
`endif
  output logic [N_DIGITS-1:0]       anodo,
  output logic [6:0]                catodo,
  output logic                      data_err
);

  // The top digit carries no nibble; it is kept free for the sign.
  localparam int ND = N_DIGITS - 1;
  localparam int MW = 4 * ND;
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  seg_scan_timer #(
    .N_DIGITS   (N_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .idx  (idx),
    .cnt  (cnt)
  );

  logic [MW-1:0]       mag_q, mag_d;
  logic                sign_q, sign_d;
  logic [N_DIGITS-1:0] anodo_q, anodo_d;
  logic [6:0]          catodo_q, catodo_d;
  logic                err_q, err_d;

  int         msd;      // most significant nonzero nibble, 0 for a zero magnitude
  int         cur;      // digit currently being scanned
  logic       nonzero;
  logic [3:0] nib;
  logic       on_time;

  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    if (load) begin
      mag_d  = codigo_BCD;
      sign_d = signo;
    end
  end

  always_comb begin
    msd      = 0;
    nonzero  = |mag_q;
    cur      = int'(idx);
    nib      = 4'h0;
    err_d    = 1'b0;
    catodo_d = SEG_BLANK;
    anodo_d  = '1;
    on_time  = 1'b1;

    for (int i = 0; i < ND; i++) begin
      // Invalid nibbles are nonzero and therefore also push msd upward.
      if (mag_q[4*i +: 4] != 4'h0) msd = i;
      if (mag_q[4*i +: 4] > 4'd9)  err_d = 1'b1;
      if (i == cur)                nib = mag_q[4*i +: 4];
    end

    if (cur < ND && (BLANK_LEADING == 0 || cur <= msd)) begin
      catodo_d = bcd_to_seg(nib);
    end else if (sign_q && nonzero &&
                 ((BLANK_LEADING != 0) ? (cur == msd + 1) : (cur == N_DIGITS - 1))) begin
      // Negative zero falls through to blank: no sign is shown.
      catodo_d = SEG_MINUS;
    end

`ifdef DISPLAY_DIM_EN
    on_time = (int'(cnt) < (((int'(brillo) + 1) * REFRESH_DIV) / 8));
`else
    // Same rule as full brightness; always true while cnt stays in its slot range.
    on_time = (int'(cnt) < REFRESH_DIV);
`endif

    if (on_time) begin
      anodo_d = ~(N_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mag_q    <= '0;
      sign_q   <= 1'b0;
      anodo_q  <= '1;
      catodo_q <= SEG_BLANK;
      err_q    <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      anodo_q  <= anodo_d;
      catodo_q <= catodo_d;
      err_q    <= err_d;
    end
  end

  assign anodo    = anodo_q;
  assign catodo   = catodo_q;
  assign data_err = err_q;

endmodule

// File: tb/tb_display_7seg_mux_param.sv
// Self-checking bench for display_7seg_mux_param with N_DIGITS=8, REFRESH_DIV=4, BLANK_LEADING=1.
// Combines a vector table, hand-written reset/scan sequences and randomized loads against a behavioural model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_display_7seg_mux_param;

  localparam int N   = 8;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [27:0] codigo_BCD = '0;
  logic        signo = 1'b0;
`ifdef DISPLAY_DIM_EN
  logic [2:0]  brillo = 3'd7;
`endif
  logic [7:0]  anodo;
  logic [6:0]  catodo;
  logic        data_err;

  display_7seg_mux_param #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (DIV),
    .BLANK_LEADING(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .codigo_BCD(codigo_BCD),
    .signo     (signo),
`ifdef DISPLAY_DIM_EN
    .brillo    (brillo),
`endif
    .anodo     (anodo),
    .catodo    (catodo),
    .data_err  (data_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: value the display should be showing and edges since reset release.
  logic [27:0] m_mag = '0;
  logic        m_sign = 1'b0;
  int          m_cyc = 0;
  int          last_pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] decode(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // Pattern for display position pos, from the digit list of the magnitude.
  function automatic logic [6:0] model_digit(input logic [27:0] mag, input logic s, input int pos);
    int d [7];
    int top = 0;
    bit nz = 0;
    for (int i = 0; i < 7; i++) begin
      d[i] = int'(mag[4*i +: 4]);
      if (d[i] != 0) begin
        top = i;
        nz  = 1;
      end
    end
    if (pos < 7 && pos <= top) return decode(d[pos]);
    if (pos == top + 1 && s && nz) return 7'b0111111;
    return 7'h7F;
  endfunction

  function automatic logic model_err(input logic [27:0] mag);
    for (int i = 0; i < 7; i++) if (mag[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: predict outputs from the pre-edge model, advance the model, compare.
  task automatic tick();
    logic [7:0] ea;
    logic [6:0] ec;
    logic       ee;
    if (!reset) begin
      ea = 8'hFF; ec = 7'h7F; ee = 1'b0;
    end else begin
      last_pos = (m_cyc / DIV) % N;
      ea = ~(8'b1 << last_pos);
      ec = model_digit(m_mag, m_sign, last_pos);
      ee = model_err(m_mag);
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      m_mag = '0; m_sign = 1'b0; m_cyc = 0;
    end else begin
      if (load) begin
        m_mag = codigo_BCD; m_sign = signo;
      end
      m_cyc++;
    end
    check("model_anodo", 32'(anodo), 32'(ea));
    check("model_catodo", 32'(catodo), 32'(ec));
    check("model_data_err", 32'(data_err), 32'(ee));
  endtask

  task automatic load_value(input logic [27:0] v, input logic s);
    codigo_BCD = v; signo = s; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    logic [27:0]     mag;
    logic            sgn;
    logic [7:0][6:0] cat;  // index = digit position
    logic            err;
  } vec_t;

  vec_t tbl [7];
  logic [7:0] anseq [8];

  initial begin
    tbl[0] = '{28'h0000028, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0100100, 7'b0000000}, 1'b0};
    tbl[1] = '{28'h0000028, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0111111, 7'b0100100, 7'b0000000}, 1'b0};
    tbl[2] = '{28'h0000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 1'b0};
    tbl[3] = '{28'h00000A3, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0000110, 7'b0110000}, 1'b1};
    tbl[4] = '{28'h0000003, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0110000}, 1'b0};
    tbl[5] = '{28'h1234567, 1'b1, {7'b0111111, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}, 1'b0};
    tbl[6] = '{28'h0100000, 1'b1, {7'h7F, 7'b0111111, 7'b1111001, 7'b1000000,
                                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b0};
    anseq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    // Reset held for three cycles.
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("reset_anodo", 32'(anodo), 32'hFF);
    check("reset_catodo", 32'(catodo), 32'h7F);
    check("reset_data_err", 32'(data_err), 32'h0);

    // Release: first digit lights on the next cycle, then the scan order.
    reset = 1'b1;
    tick();
    check("release_anodo", 32'(anodo), 32'hFE);
    for (int k = 1; k < 36; k++) begin
      tick();
      check("scan_anodo", 32'(anodo), 32'(anseq[(k / DIV) % N]));
    end

    // Table vectors: load, let the decode register catch up, then scan all digits.
    for (int v = 0; v < 7; v++) begin
      load_value(tbl[v].mag, tbl[v].sgn);
      tick();
      check("tbl_err_after_load", 32'(data_err), 32'(tbl[v].err));
      for (int k = 0; k < N * DIV; k++) begin
        tick();
        check($sformatf("tbl%0d_catodo", v), 32'(catodo), 32'(tbl[v].cat[last_pos]));
      end
    end

    // Load held high recaptures every cycle without disturbing the scan.
    codigo_BCD = 28'h0000001; signo = 1'b0; load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      codigo_BCD = 28'(k + 1);
      tick();
    end
    load = 1'b0;
    tick();

    // Reset asserted mid-scan at index 5, counter 2, with a nonzero shadow.
    load_value(28'h0000999, 1'b1);
    for (int k = 0; k < 64 && m_cyc % (N * DIV) != 5 * DIV + 2; k++) tick();
    check("midscan_position", 32'(m_cyc % (N * DIV)), 32'(5 * DIV + 2));
    reset = 1'b0;
    tick();
    check("midscan_reset_anodo", 32'(anodo), 32'hFF);
    check("midscan_reset_catodo", 32'(catodo), 32'h7F);
    reset = 1'b1;
    tick();
    check("restart_anodo", 32'(anodo), 32'hFE);
    check("restart_shadow_cleared", 32'(catodo), 32'b1000000);

    // Randomized loads: mixed widths, occasional invalid nibbles, random signs.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        logic [27:0] v;
        int nd;
        v  = '0;
        nd = $urandom_range(0, 7);
        for (int i = 0; i < nd; i++) begin
          if ($urandom_range(0, 11) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
          else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        codigo_BCD = v;
        signo = 1'($urandom_range(0, 1));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_7seg_mux_param.md
Name: display_7seg_mux_param

Overview:
Parametrised successor of the team's fixed 5-digit display driver. It time-multiplexes an N-digit common-anode 7-segment display from a sign bit plus packed BCD magnitude. It adds:
- a load-strobed shadow register, so the display never shows a partially updated value;
- leading-zero blanking with a floating minus sign;
- an invalid-digit indication.

It sits between the Booth result BCD converter and the board display pins.

Parameters:
N_DIGITS, 8, number of physical digits/anodes (≥2); one is always reserved for sign space.
REFRESH_DIV, 100000, clk cycles each digit stays lit (≥2).
BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset=0 resets on rising clk)
load  in  1  strobe: capture codigo_BCD/signo this cycle
codigo_BCD  in  4*(N_DIGITS-1)  packed BCD magnitude, nibble 0 = least significant digit
signo  in  1  1 = negative
anodo  out  N_DIGITS  active-low digit enables, bit i = digit i
catodo  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
data_err  out  1  1 = shadow holds a nibble >9

Behaviour:
- Reset (reset=0 at edge):
  - anodo = all ones; catodo = 7'h7F; data_err = 0.
  - Shadow magnitude = 0, shadow sign = 0, refresh counter = 0, digit index = 0.
  - Reset mid-scan takes effect at that edge regardless of counter/index state.
- Load:
  - load=1 at an edge copies codigo_BCD/signo into the shadow.
  - The new value is visible on catodo/data_err 1 cycle later (registered decode).
  - load held high recaptures every cycle.
  - Load does not disturb the counter or index.
- Scan:
  - The counter runs 0..REFRESH_DIV-1 and then wraps.
  - On wrap, index increments modulo N_DIGITS (N_DIGITS-1 → 0).
  - anodo/catodo are registered from the current index, so the outputs lag the index by 1 cycle.
  - Exactly one anodo bit is low at any time after the first post-reset cycle.
- Digit content for position i (let m = index of most significant nonzero nibble; m = 0 if the magnitude is zero):
  - i ≤ m, or BLANK_LEADING=0, with i < N_DIGITS-1: decode nibble i.
  - i = m+1, signo=1 and magnitude ≠ 0: '-' (0111111). Position m+1 always exists because the top digit has no nibble.
  - Negative zero shows '0' with no sign.
  - Otherwise: blank (1111111).
  - With BLANK_LEADING=0, the sign always goes in digit N_DIGITS-1.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 = 'E' 0000110 and sets data_err.
  - A nonzero invalid nibble counts as nonzero when computing m.
- data_err is recomputed from the shadow each cycle (registered) and clears when valid data is loaded.

Optional Feature:
Macro DISPLAY_DIM_EN.
- Defined:
  - Adds input port brillo[2:0].
  - The active anode is driven low only while counter < ((brillo+1)*REFRESH_DIV)/8; otherwise anodo is all ones. catodo is unchanged.
  - brillo=7 gives full on-time.
  - brillo is sampled every cycle.
- Undefined: no brillo port; the anode is on for the whole slot. Behaviour is identical to brillo=7.

Decomposition:
- Package display_pkg holds:
  - segment constants SEG_BLANK, SEG_MINUS, SEG_ERR;
  - the digit-pattern array;
  - function bcd_to_seg(logic [3:0]) returning logic [6:0].
- One natural sub-module: seg_scan_timer. It contains the refresh counter and index with parameters REFRESH_DIV and N_DIGITS, and outputs index and counter.
- The top module holds the shadow register, blanking/sign logic and output registers.

Test Plan:
All scenarios use N_DIGITS=8, REFRESH_DIV=4, BLANK_LEADING=1.
1. Hold reset=0 for 3 cycles → anodo=8'hFF, catodo=7'h7F, data_err=0. Release → next cycle anodo=8'hFE.
2. Free run → anodo steps FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each, then wraps to FE.
3. Load codigo_BCD=28'h0000028, signo=0 → digit0 catodo 0000000, digit1 0100100, digits2–7 1111111.
4. Same value with signo=1 → digit2 shows 0111111. Load 28'h0, signo=1 → digit0 1000000, all other digits blank, no '-'.
5. Load 28'h00000A3 → digit1 0000110, data_err=1 one cycle after load. Load 28'h3 → data_err returns to 0.
6. Assert reset=0 while index=5, counter=2 → next cycle anodo=8'hFF and the shadow is cleared. After release, the scan restarts at digit 0 (anodo=8'hFE).
